// File: rtl/cmn_fifo_rd.sv
// Read-side drainer for cmn_fifo: pops the FIFO head into a 2-entry skid buffer
// and presents it as a registered valid/ready stream with a transfer counter.
module cmn_fifo_rd #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_rdata,
  output logic          fifo_re,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  input  logic          m_ready,
  input  logic          flush,
  output logic [CW-1:0] cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t        state, state_nxt;
  logic          wr_idx, rd_idx;
  logic [DW-1:0] mem [2];
  logic          push, pop;

  // Pop strobe depends only on occupancy, never on m_ready; rst gates it so
  // nothing is popped while the buffer is held in reset.
  assign fifo_re = !rst && !fifo_empty && !flush && (state != FULL);
  assign push    = fifo_re;
  assign m_valid = (state != EMPTY);
  assign pop     = m_valid && m_ready;
  assign m_data  = mem[rd_idx];

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = FULL;
        else if (pop && !push) state_nxt = EMPTY;
      end
      FULL:    if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
    if (flush) state_nxt = EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
    end else if (flush) begin
      state  <= EMPTY;
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) wr_idx <= ~wr_idx;
      if (pop)  rd_idx <= ~rd_idx;
    end
  end

  // A pop coinciding with flush still completes, so the counter ignores flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (pop) cnt <= cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= fifo_rdata;
  end

endmodule

// File: tb/tb_cmn_fifo_rd.sv
// Scoreboard bench for cmn_fifo_rd: a queue models the FIFO, a second queue
// holds words expected on the stream in order.
module tb_cmn_fifo_rd;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_re;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b0;
  logic          flush = 1'b0;
  logic [CW-1:0] cnt;

  logic [DW-1:0] src [$];
  logic [DW-1:0] exp_q [$];
  logic [CW-1:0] exp_cnt = '0;
  int            n_cmp = 0;
  int            n_err = 0;
  int            n_push = 0;

  cmn_fifo_rd #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_re(fifo_re), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .flush(flush), .cnt(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_src();
    fifo_empty = (src.size() == 0);
    fifo_rdata = (src.size() != 0) ? src[0] : '0;
  endtask

  // One cycle: called at posedge+1, checks combinational outputs, advances the
  // model across the edge and checks the counter afterwards.
  task automatic step(input logic rdy, input logic fl);
    logic exp_re;
    logic do_pop;
    m_ready = rdy;
    flush   = fl;
    drive_src();
    #1;
    exp_re = (src.size() != 0) && !fl && (exp_q.size() < 2);
    do_pop = (exp_q.size() != 0) && rdy;
    chk("m_valid", 32'(m_valid), 32'(exp_q.size() != 0));
    chk("fifo_re", 32'(fifo_re), 32'(exp_re));
    if (exp_q.size() != 0) chk("m_data", m_data, exp_q[0]);
    if (do_pop) begin
      void'(exp_q.pop_front());
      exp_cnt++;
    end
    if (fl) exp_q.delete();
    if (exp_re) begin
      exp_q.push_back(src.pop_front());
      n_push++;
    end
    @(posedge clk);
    #1;
    chk("cnt", 32'(cnt), 32'(exp_cnt));
  endtask

  initial begin
    for (int i = 1; i <= 8; i++) src.push_back(32'(i));
    drive_src();
    #12;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_fifo_re", 32'(fifo_re), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // streaming 0x1..0x8
    n_push = 0;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    chk("stream_pushes", 32'(n_push), 32'd8);
    chk("stream_cnt", 32'(cnt), 32'd8);

    // backpressure 0xA0..0xA3
    for (int i = 0; i < 4; i++) src.push_back(32'hA0 + 32'(i));
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      chk("bp_hold", m_data, 32'hA0);
    end
    chk("bp_full_re", 32'(fifo_re), 32'd0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
    chk("bp_cnt", 32'(cnt), 32'd12);

    // alternating ready with 6 words
    for (int i = 0; i < 6; i++) src.push_back(32'hB0 + 32'(i));
    for (int i = 0; i < 14; i++) step(1'(i % 2 == 0), 1'b0);
    chk("alt_drained", 32'(exp_q.size()), 32'd0);
    chk("alt_cnt", 32'(cnt), 32'd2);

    // flush while FULL with 0x11,0x12; 0x13 arrives afterwards
    src.push_back(32'h11);
    src.push_back(32'h12);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    src.push_back(32'h13);
    step(1'b1, 1'b1);
    chk("flush_cnt", 32'(cnt), 32'd3);
    chk("flush_valid", 32'(m_valid), 32'd0);
    step(1'b0, 1'b0);
    chk("flush_next", m_data, 32'h13);
    step(1'b1, 1'b0);

    // counter wrap: 17 transfers through 4-bit counter
    for (int i = 0; i < 17; i++) src.push_back(32'hC00 + 32'(i));
    for (int i = 0; i < 19; i++) step(1'b1, 1'b0);
    chk("wrap_cnt", 32'(cnt), 32'd5);

    // asynchronous reset while FULL
    for (int i = 0; i < 6; i++) src.push_back(32'hD0 + 32'(i));
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(m_valid), 32'd0);
    chk("arst_cnt", 32'(cnt), 32'd0);
    chk("arst_re", 32'(fifo_re), 32'd0);
    exp_q.delete();
    exp_cnt = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_valid", 32'(m_valid), 32'd0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
    chk("post_rst_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cmn_fifo_rd.md
CMN_FIFO_RD -- requirements
Module: cmn_fifo_rd

Purpose: read-side drainer for cmn_fifo. Pops words from the FIFO's combinational read port and presents them as a registered valid/ready stream through a 2-entry skid buffer, with a transfer counter and a flush control.

Interface
REQ-001 The module SHALL have parameter DW, default 32, giving the data width in bits.
REQ-002 The module SHALL have parameter CW, default 16, giving the transfer counter width in bits.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port fifo_empty, input, 1 bit: FIFO empty flag.
REQ-006 Port fifo_rdata, input, DW bits: FIFO head word; valid in the same cycle whenever fifo_empty=0.
REQ-007 Port fifo_re, output, 1 bit: FIFO pop strobe; one word is popped per cycle it is high.
REQ-008 Port m_valid, output, 1 bit: stream output valid.
REQ-009 Port m_data, output, DW bits: stream output data.
REQ-010 Port m_ready, input, 1 bit: stream sink ready.
REQ-011 Port flush, input, 1 bit: synchronous discard of buffered words.
REQ-012 Port cnt, output, CW bits: count of completed output transfers.

Function
REQ-013 The buffer SHALL be 2 entries, addressed by a 1-bit write index and a 1-bit read index, with an occupancy FSM having states EMPTY(0), ONE(1) and FULL(2).
REQ-014 Definitions: push = fifo_re; pop = m_valid && m_ready.
REQ-015 fifo_re SHALL equal (!fifo_empty && !flush && state!=FULL). There SHALL be no combinational path from m_ready to fifo_re.
REQ-016 On push, fifo_rdata SHALL be written to entry[wr_idx] and wr_idx SHALL toggle.
REQ-017 On pop, rd_idx SHALL toggle.
REQ-018 m_valid SHALL equal (state!=EMPTY), and m_data SHALL equal entry[rd_idx]. Both come from registers only.
REQ-019 FSM transitions:
  - EMPTY: push -> ONE.
  - ONE: push&&!pop -> FULL; pop&&!push -> EMPTY; push&&pop -> ONE.
  - FULL: pop -> ONE; push cannot occur in FULL.
  - In all other cases the state is held.
REQ-020 Latency: a word present at the FIFO head while the buffer is EMPTY SHALL appear on m_valid/m_data in the cycle after fifo_re.
REQ-021 Throughput: with fifo_empty=0 and m_ready=1 continuously, one word SHALL transfer per cycle in steady state.
REQ-022 While m_valid=1 and m_ready=0, m_data and m_valid SHALL hold stable.
REQ-023 Ordering: output words SHALL appear in exact FIFO pop order, with no loss or duplication except on flush.
REQ-024 Flush has the highest priority. When flush=1 at an edge:
  - state SHALL go to EMPTY and wr_idx/rd_idx SHALL reset to 0;
  - fifo_re SHALL be 0 in that cycle;
  - m_valid SHALL be 0 in the next cycle.
REQ-025 A pop coinciding with flush SHALL still count as a completed transfer; the remaining buffered words SHALL be discarded uncounted.
REQ-026 cnt SHALL increment by 1 on each pop, wrap from 2^CW-1 to 0, and be unaffected by flush.
REQ-027 When fifo_empty=1, fifo_re SHALL be 0 and the buffer SHALL drain normally.

Reset
REQ-028 While rst=1, asynchronously: state=EMPTY, wr_idx=rd_idx=0, cnt=0, m_valid=0, fifo_re=0.
REQ-029 Entry data registers SHALL NOT require reset, and m_data is don't-care while m_valid=0.
REQ-030 Reset asserted mid-transfer SHALL discard all buffered words. After deassertion, operation SHALL resume from the current FIFO head, with no spurious m_valid.

Verification
REQ-031 Streaming: FIFO preloaded with 0x1..0x8, m_ready=1 -> m_data 0x1..0x8 on consecutive cycles starting 1 cycle after the first fifo_re; cnt=8; fifo_re high for exactly 8 cycles.
REQ-032 Backpressure: 4 words queued (0xA0..0xA3), m_ready=0 for 5 cycles then 1 -> state FULL after 2 cycles; fifo_re=0 while FULL; m_data=0xA0 held stable; then 0xA0..0xA3 delivered in order, cnt=4.
REQ-033 Alternating m_ready (1010...) with 6 words -> all 6 delivered in order, none duplicated, cnt=6.
REQ-034 Flush: buffer FULL (0x11,0x12), flush=1 with m_ready=1 -> 0x11 counted (cnt+1); next cycle m_valid=0 and 0x12 is dropped; after flush the next FIFO word 0x13 appears.
REQ-035 Wrap: CW=4 with 17 transfers -> cnt sequence 0..15, 0, 1.
REQ-036 Reset: rst asserted while FULL and mid-stream -> m_valid=0 and cnt=0 immediately (asynchronous); after release, the next FIFO head is delivered first.
